// File: rtl/cassette_recorder.sv
// Cassette write path: FSK demodulator (CoCo/Dragon, LSB first) feeding a small
// byte FIFO that is drained into sequential SDRAM writes to build a CAS image.
module cassette_recorder #(
  parameter logic [24:0] BASE_ADDR  = 25'h0,
  parameter int          THRESH     = 559,
  parameter int          MIN_PERIOD = 200,
  parameter int          MAX_PERIOD = 1200,
  parameter int          HYST_HI    = 36,
  parameter int          HYST_LO    = 28,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Q,
  input  logic        en,
  input  logic [5:0]  snd_in,
  input  logic        rewind,
  output logic [24:0] sdram_addr,
  output logic [7:0]  sdram_data,
  output logic        sdram_wr,
  input  logic        sdram_ack,
  output logic [15:0] byte_count,
  output logic        recording,
  output logic        overflow
);

  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam logic [11:0] THRESH_P   = 12'(THRESH);
  localparam logic [11:0] MIN_P      = 12'(MIN_PERIOD);
  localparam logic [11:0] MAX_P      = 12'(MAX_PERIOD);
  localparam logic [5:0]  HYST_HI_L  = 6'(HYST_HI);
  localparam logic [5:0]  HYST_LO_L  = 6'(HYST_LO);
  localparam logic [AW:0] FIFO_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_e;

  state_e        state_q;
  logic          cmp_q;
  logic [11:0]   period_q;
  logic [2:0]    bitCnt_q;
  logic [7:0]    shift_q;
  logic          pushValid_q;
  logic [7:0]    pushByte_q;
  logic          recording_q;

  logic          riseEdge_d;
  logic          bitOne_d;
  logic [7:0]    shift_d;

  logic [7:0]    fifoMem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [AW:0]   fifoCnt_q;
  logic          wr_q;
  logic [24:0]   addr_q;
  logic [7:0]    data_q;
  logic [15:0]   byteCount_q;
  logic          overflow_q;

  logic          push_d;
  logic          pop_d;
  logic [16:0]   reserved_d;

  always_comb begin
    riseEdge_d = Q && !cmp_q && (snd_in >= HYST_HI_L);
    bitOne_d   = (period_q < THRESH_P);
    shift_d    = {bitOne_d, shift_q[7:1]};
  end

  // Demodulator: periods are measured between comparator rising edges.
  always_ff @(posedge clk) begin
    if (reset || rewind) begin
      state_q     <= IDLE;
      cmp_q       <= 1'b0;
      period_q    <= 12'd0;
      bitCnt_q    <= 3'd0;
      shift_q     <= 8'd0;
      pushValid_q <= 1'b0;
      pushByte_q  <= 8'd0;
      recording_q <= 1'b0;
    end else begin
      pushValid_q <= 1'b0;
      if (Q) begin
        if (snd_in >= HYST_HI_L) begin
          cmp_q <= 1'b1;
        end else if (snd_in <= HYST_LO_L) begin
          cmp_q <= 1'b0;
        end
      end
      if (!en) begin
        state_q     <= IDLE;
        period_q    <= 12'd0;
        bitCnt_q    <= 3'd0;
        shift_q     <= 8'd0;
        recording_q <= 1'b0;
      end else if (Q) begin
        if (period_q != 12'hFFF) begin
          period_q <= period_q + 12'd1;
        end
        if (riseEdge_d) begin
          unique case (state_q)
            IDLE: begin
              state_q     <= MEASURE;
              period_q    <= 12'd0;
              recording_q <= 1'b1;
            end
            MEASURE: begin
              if (period_q >= MIN_P) begin
                period_q <= 12'd0;
                // An over-long period means we lost sync, so realign bytes.
                if (period_q > MAX_P) begin
                  bitCnt_q <= 3'd0;
                  shift_q  <= 8'd0;
                end else begin
                  shift_q  <= shift_d;
                  bitCnt_q <= bitCnt_q + 3'd1;
                  if (bitCnt_q == 3'd7) begin
                    pushValid_q <= 1'b1;
                    pushByte_q  <= shift_d;
                  end
                end
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    pop_d      = wr_q && sdram_ack;
    reserved_d = {1'b0, byteCount_q} + 17'(fifoCnt_q);
    push_d     = pushValid_q && ((fifoCnt_q != FIFO_FULL) || pop_d) &&
                 (reserved_d < 17'h0FFFF);
  end

  always_ff @(posedge clk) begin
    if (push_d) begin
      fifoMem_q[wrPtr_q] <= pushByte_q;
    end
  end

  // FIFO bookkeeping and the SDRAM write handshake.
  always_ff @(posedge clk) begin
    if (reset || rewind) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fifoCnt_q   <= '0;
      wr_q        <= 1'b0;
      addr_q      <= BASE_ADDR;
      data_q      <= 8'd0;
      byteCount_q <= 16'd0;
      overflow_q  <= 1'b0;
    end else begin
      if (push_d) begin
        wrPtr_q <= wrPtr_q + PTR_ONE;
      end
      if (pushValid_q && !push_d) begin
        overflow_q <= 1'b1;
      end
      if (pop_d) begin
        rdPtr_q <= rdPtr_q + PTR_ONE;
      end
      unique case ({push_d, pop_d})
        2'b10:   fifoCnt_q <= fifoCnt_q + CNT_ONE;
        2'b01:   fifoCnt_q <= fifoCnt_q - CNT_ONE;
        default: fifoCnt_q <= fifoCnt_q;
      endcase
      if (pop_d) begin
        wr_q        <= 1'b0;
        byteCount_q <= byteCount_q + 16'd1;
      end else if (!wr_q && (fifoCnt_q != '0)) begin
        wr_q   <= 1'b1;
        addr_q <= BASE_ADDR + 25'(byteCount_q);
        data_q <= fifoMem_q[rdPtr_q];
      end
    end
  end

  assign sdram_wr   = wr_q;
  assign sdram_addr = addr_q;
  assign sdram_data = data_q;
  assign byte_count = byteCount_q;
  assign recording  = recording_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_cassette_recorder.sv
// Scoreboard bench for cassette_recorder: directed FSK waveforms in, expected
// SDRAM writes queued by the stimulus and checked by an independent monitor.
module tb_cassette_recorder;

  logic        clk = 1'b0;
  logic        reset;
  logic        Q;
  logic        en;
  logic [5:0]  snd_in;
  logic        rewind;
  logic [24:0] sdram_addr;
  logic [7:0]  sdram_data;
  logic        sdram_wr;
  logic        sdram_ack;
  logic [15:0] byte_count;
  logic        recording;
  logic        overflow;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t expQ[$];
  exp_t expHead;
  int   compared   = 0;
  int   mismatched = 0;
  int   ackDelay   = 0;
  int   waitCnt    = 0;
  logic ackHold    = 1'b0;
  logic forceAck   = 1'b0;
  logic stableBad  = 1'b0;

  always #5 clk = ~clk;

  cassette_recorder dut (
    .clk        (clk),
    .reset      (reset),
    .Q          (Q),
    .en         (en),
    .snd_in     (snd_in),
    .rewind     (rewind),
    .sdram_addr (sdram_addr),
    .sdram_data (sdram_data),
    .sdram_wr   (sdram_wr),
    .sdram_ack  (sdram_ack),
    .byte_count (byte_count),
    .recording  (recording),
    .overflow   (overflow)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [5:0] level, input int ticks);
    snd_in = level;
    tick(ticks);
  endtask

  task automatic sendCycle(input int p);
    applyStimulus(6'd63, p / 2);
    applyStimulus(6'd0, p - p / 2);
  endtask

  // Short extra pulse 100 ticks after the edge; must not count as a period.
  task automatic sendGlitchCycle(input int p);
    applyStimulus(6'd63, 50);
    applyStimulus(6'd0, 50);
    applyStimulus(6'd63, 100);
    applyStimulus(6'd0, p - 200);
  endtask

  task automatic sendByte(input logic [7:0] b, input int glitchBit);
    for (int i = 0; i < 8; i++) begin
      if (i == glitchBit) sendGlitchCycle(b[i] ? 373 : 746);
      else                sendCycle(b[i] ? 373 : 746);
    end
  endtask

  task automatic sendEdge();
    applyStimulus(6'd63, 200);
    applyStimulus(6'd0, 1250);
  endtask

  task automatic expectWrite(input logic [24:0] addr, input logic [7:0] data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    expQ.push_back(e);
  endtask

  task automatic waitDrain(input int limit);
    int n = 0;
    while (expQ.size() != 0 && n < limit) begin
      tick(1);
      n++;
    end
    checkOutput("drain_pending", expQ.size(), 0);
    tick(3);
  endtask

  task automatic doRewind();
    rewind = 1'b1;
    tick(1);
    rewind = 1'b0;
    tick(1);
  endtask

  // SDRAM responder: acks after ackDelay cycles of a raised request.
  initial begin
    sdram_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      sdram_ack = 1'b0;
      if (sdram_wr && !ackHold) begin
        if (waitCnt >= ackDelay) begin
          sdram_ack = 1'b1;
          waitCnt   = 0;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
      if (forceAck) sdram_ack = 1'b1;
    end
  end

  // Monitor: every accepted write is compared with the head of the queue.
  always @(negedge clk) begin
    if (!reset && sdram_wr) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_write: got addr %0h data %0h, wanted no write",
                 sdram_addr, sdram_data);
      end else if (sdram_ack) begin
        expHead = expQ.pop_front();
        checkOutput("write_addr", 32'(sdram_addr), 32'(expHead.addr));
        checkOutput("write_data", 32'(sdram_data), 32'(expHead.data));
        checkOutput("write_stable", 32'(stableBad), 32'd0);
        stableBad = 1'b0;
      end else if (sdram_addr !== expQ[0].addr || sdram_data !== expQ[0].data) begin
        stableBad = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    Q      = 1'b1;
    en     = 1'b1;
    snd_in = 6'd0;
    rewind = 1'b0;
    tick(3);
    checkOutput("reset_wr", 32'(sdram_wr), 32'd0);
    checkOutput("reset_addr", 32'(sdram_addr), 32'h0);
    checkOutput("reset_data", 32'(sdram_data), 32'h0);
    checkOutput("reset_count", 32'(byte_count), 32'd0);
    checkOutput("reset_recording", 32'(recording), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    tick(2);

    $display("[TB] single byte A5");
    expectWrite(25'h0, 8'hA5);
    sendByte(8'hA5, -1);
    sendEdge();
    waitDrain(500);
    checkOutput("a5_count", 32'(byte_count), 32'd1);
    checkOutput("a5_recording", 32'(recording), 32'd1);

    $display("[TB] two bytes, slow ack, glitch inside 55");
    doRewind();
    ackDelay = 10;
    expectWrite(25'h0, 8'h55);
    expectWrite(25'h1, 8'h3C);
    sendByte(8'h55, 1);
    sendByte(8'h3C, -1);
    sendEdge();
    waitDrain(500);
    checkOutput("two_count", 32'(byte_count), 32'd2);
    ackDelay = 0;

    $display("[TB] partial byte, gap, then FF");
    doRewind();
    expectWrite(25'h0, 8'hFF);
    sendCycle(373);
    sendCycle(746);
    sendCycle(373);
    sendCycle(1500);
    sendByte(8'hFF, -1);
    sendEdge();
    waitDrain(500);
    checkOutput("gap_count", 32'(byte_count), 32'd1);

    $display("[TB] FIFO full with ack held");
    doRewind();
    ackHold = 1'b1;
    expectWrite(25'h0, 8'hFE);
    expectWrite(25'h1, 8'hFD);
    expectWrite(25'h2, 8'hFB);
    expectWrite(25'h3, 8'hF7);
    sendByte(8'hFE, -1);
    sendByte(8'hFD, -1);
    sendByte(8'hFB, -1);
    sendByte(8'hF7, -1);
    sendByte(8'hFF, -1);
    sendEdge();
    checkOutput("ovf_set", 32'(overflow), 32'd1);
    checkOutput("ovf_held_count", 32'(byte_count), 32'd0);
    checkOutput("ovf_held_wr", 32'(sdram_wr), 32'd1);
    ackHold = 1'b0;
    waitDrain(500);
    checkOutput("ovf_count", 32'(byte_count), 32'd4);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);

    $display("[TB] rewind during an outstanding write");
    ackHold = 1'b1;
    expectWrite(25'h4, 8'hC3);
    sendByte(8'hC3, -1);
    sendEdge();
    checkOutput("abort_wr_up", 32'(sdram_wr), 32'd1);
    rewind = 1'b1;
    tick(1);
    checkOutput("abort_wr", 32'(sdram_wr), 32'd0);
    checkOutput("abort_count", 32'(byte_count), 32'd0);
    checkOutput("abort_overflow", 32'(overflow), 32'd0);
    checkOutput("abort_addr", 32'(sdram_addr), 32'h0);
    rewind = 1'b0;
    void'(expQ.pop_front());
    stableBad = 1'b0;
    forceAck  = 1'b1;
    tick(1);
    forceAck  = 1'b0;
    tick(2);
    checkOutput("late_ack_count", 32'(byte_count), 32'd0);
    ackHold = 1'b0;
    expectWrite(25'h0, 8'h81);
    sendByte(8'h81, -1);
    sendEdge();
    waitDrain(500);
    checkOutput("after_abort_count", 32'(byte_count), 32'd1);

    $display("[TB] hysteresis band and relay off");
    doRewind();
    for (int i = 0; i < 20; i++) begin
      applyStimulus((i % 2 == 0) ? 6'd34 : 6'd30, 100);
    end
    checkOutput("hyst_recording", 32'(recording), 32'd0);
    applyStimulus(6'd63, 10);
    checkOutput("edge_recording", 32'(recording), 32'd1);
    en = 1'b0;
    tick(1);
    checkOutput("en_off_recording", 32'(recording), 32'd0);
    applyStimulus(6'd0, 200);
    sendByte(8'hFF, -1);
    sendEdge();
    checkOutput("en_off_count", 32'(byte_count), 32'd0);
    checkOutput("en_off_wr", 32'(sdram_wr), 32'd0);
    en = 1'b1;
    tick(5);
    checkOutput("final_queue", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cassette_recorder.md
Name: cassette_recorder

Overview:
- Write-side counterpart of the cassette playback path.
- Samples the machine's 6-bit cassette DAC output while the cassette relay is engaged and demodulates CoCo/Dragon FSK (2400 Hz cycle = 1, 1200 Hz cycle = 0, LSB first).
- Packs decoded bits into bytes, buffers them in a small FIFO and writes them sequentially to SDRAM, producing a CAS image for later upload.
- Sits beside the cassette reader, sharing the Q clock-enable and the SDRAM tape region.

Parameters:
BASE_ADDR, 25'h0, SDRAM byte address of the first recorded byte
THRESH, 559, period in Q ticks separating a 1-bit (below) from a 0-bit (at or above)
MIN_PERIOD, 200, periods shorter than this are glitches
MAX_PERIOD, 1200, periods longer than this are gaps (resync)
HYST_HI, 36, comparator rises when snd_in >= HYST_HI
HYST_LO, 28, comparator falls when snd_in <= HYST_LO
FIFO_DEPTH, 4, byte FIFO entries (power of 2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
Q  in  1  one-clk enable pulse at the 6809 Q rate (~894.886 kHz)
en  in  1  cassette relay; recording only while high
snd_in  in  6  cassette DAC value from the PIA
rewind  in  1  level; clears the write pointer and status
sdram_addr  out  25  write address
sdram_data  out  8  write data
sdram_wr  out  1  write request, held until acknowledged
sdram_ack  in  1  one-cycle completion strobe from the SDRAM controller
byte_count  out  16  bytes committed to SDRAM since the last rewind/reset
recording  out  1  en high and the first edge has been seen
overflow  out  1  sticky; a byte was dropped

Behaviour:
- Reset values: sdram_wr=0, sdram_addr=BASE_ADDR, sdram_data=0, byte_count=0, recording=0, overflow=0. Reset also empties the FIFO and clears all demodulator state.
- rewind has the same effect as reset on all state. It aborts an outstanding write immediately: sdram_wr=0 the next cycle, and a late ack is ignored.
- Comparator: updated only on Q ticks using the HYST_HI/HYST_LO rules; resets low. A rising edge is a 0->1 transition of the comparator.
- Period counter: 12-bit, increments on each Q tick, saturates at 4095. While en=0 it is held at 0, the bit counter is cleared, a partial byte is discarded and recording=0.
- Demodulator states are IDLE and MEASURE:
  - IDLE: on the first rising edge with en=1, go to MEASURE, clear the counter, set recording=1.
  - MEASURE, edge with count < MIN_PERIOD: ignored; the counter keeps running.
  - MEASURE, MIN_PERIOD <= count < THRESH: emit bit 1.
  - MEASURE, THRESH <= count <= MAX_PERIOD: emit bit 0.
  - MEASURE, count > MAX_PERIOD: no bit; the bit counter and partial byte are cleared (byte realign).
  - Every non-glitch edge restarts the counter at 0 on that tick.
- Byte assembly: bits shift in LSB first. On the 8th bit the byte is pushed to the FIFO on the following clk, and the bit counter returns to 0.
- FIFO push when full: the byte is dropped and overflow is set.
- Write pointer: when byte_count = 16'hFFFF, further bytes are dropped and overflow is set. There is no wrap.
- Write handshake:
  - When the FIFO is not empty and sdram_wr=0, the next cycle drives sdram_wr=1 with the head byte on sdram_data and sdram_addr = BASE_ADDR + byte_count.
  - sdram_wr, sdram_addr and sdram_data stay stable until sdram_ack.
  - On the ack cycle: pop the FIFO, increment byte_count, deassert sdram_wr next cycle. At least one idle cycle separates writes.
- Simultaneous push and pop in one cycle are both honoured; the FIFO count is unchanged.
- The FIFO keeps draining after en falls.
- overflow clears only on reset or rewind.

Test Plan:
- Reset, Q every clk, en=1, 8 square-wave cycles of snd_in 0/63 with periods 373,746,373,746,746,373,746,373 -> one write of 8'hA5 at BASE_ADDR; byte_count=1 after ack; recording=1.
- Two consecutive bytes 8'h55 then 8'h3C, with ack delayed 10 cycles -> writes at BASE_ADDR and BASE_ADDR+1 in order; sdram_wr stable through each delay; byte_count=2.
- Insert a 100-tick glitch pulse mid-cycle, then a 1500-tick gap after 3 bits, then a full byte 8'hFF -> glitch ignored, partial byte discarded, single write of 8'hFF.
- Hold sdram_ack=0 while 5 bytes arrive -> 4 bytes buffered, 5th dropped, overflow=1; release ack -> exactly 4 writes.
- Assert rewind while sdram_wr=1 -> sdram_wr=0 next cycle, byte_count=0, overflow=0; the next byte goes to BASE_ADDR.
- snd_in oscillating between 30 and 34 -> no comparator edges, no writes; en=0 with a valid waveform -> no writes and recording=0.
